spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI target (slave) end of the APB-to-SPI link: receives frames a master drives on
//  ss/sclk/mosi and returns data on miso. All SPI pins are sampled in the PCLK domain.
//  A byte-wide host side with valid/ready pairs supplies TX bytes and delivers RX bytes.
//  Used as the bench/system counterpart for the SPI master. All modes supported (CPOL/CPHA, LSBFE).
// PARAMETERS
//  DATA_WIDTH   8   frame length in bits
//  SYNC_STAGES  2   synchroniser flops on ss_i, sclk_i, mosi_i (>=2)
// PORTS
//  PCLK         in   1   system clock; all logic on rising edge
//  PRESET       in   1   synchronous, active-high reset
//  cpol_i       in   1   SCLK idle level; static while ss_i low
//  cpha_i       in   1   0: sample leading edge, 1: sample trailing edge
//  lsbfe_i      in   1   1: LSB first on both miso and mosi
//  ss_i         in   1   slave select, active low
//  sclk_i       in   1   SPI clock from master; half-period >= 4 PCLK
//  mosi_i       in   1   serial data from master
//  miso_o       out  1   serial data to master
//  miso_oe_o    out  1   miso output enable; high only while selected
//  tx_data_i    in   DW  next byte to return
//  tx_valid_i   in   1   tx_data_i valid
//  tx_ready_o   out  1   TX holding register empty
//  rx_data_o    out  DW  last complete received byte
//  rx_valid_o   out  1   rx_data_o unread; held until rx_ready_i
//  rx_ready_i   in   1   host consumes rx_data_o
//  busy_o       out  1   frame in progress (state != IDLE)
//  underrun_o   out  1   sticky: frame started with TX register empty
//  overrun_o    out  1   sticky: RX byte completed while rx_valid_o high
//  abort_o      out  1   1-cycle pulse: ss_i rose mid-frame
//  clr_status_i in   1   clears underrun_o/overrun_o
// BEHAVIOUR
//  Reset: miso_o=0, miso_oe_o=0, rx_data_o=0, rx_valid_o=0, tx_ready_o=1, busy_o=0,
//   status flags 0, state IDLE, TX holding register empty, bit counter 0.
//  Sync: ss/sclk/mosi pass SYNC_STAGES flops. Edges are detected on the synced sclk
//   against its previous value. Detection lags the pin by SYNC_STAGES+1 PCLK.
//  Sample edge = rising when cpol_i==cpha_i, else falling. Drive edge = the opposite edge.
//  TX holding reg: loads on tx_valid_i&&tx_ready_o; tx_ready_o=0 until consumed at LOAD.
//  FSM:
//   IDLE : miso_oe_o=0; synced ss falls -> LOAD.
//   LOAD : 1 cycle. tx shift <= holding reg, or 0 and set underrun_o if empty (frees reg).
//          Holding-reg write in the same cycle is kept for the next frame.
//          miso_o <= first bit (bit0 if lsbfe_i, else bit DW-1); miso_oe_o=1; cnt=0 -> SHIFT.
//   SHIFT: sample edge: shift mosi into rx shift, cnt++.
//          Drive edge: present next TX bit only if cnt>0 and cnt<DW; the
//           CPHA=1 leading edge and the post-final-sample edge do not advance.
//          cnt==DW after a sample -> DONE. Synced ss rises -> abort_o pulse,
//           partial byte dropped, rx_valid_o untouched -> IDLE.
//   DONE : 1 cycle. rx_data_o <= rx shift; rx_valid_o=1; overrun_o set if already 1.
//          Then ss low -> LOAD (back-to-back frame), ss high -> IDLE.
//  rx_valid_o drops on rx_ready_i. Simultaneous DONE and rx_ready_i: new byte wins,
//   rx_valid_o stays 1, no overrun.
//  clr_status_i coincident with a set event: the set wins.
//  Mode inputs are sampled each cycle; changes while busy_o=1 are undefined use.
//  PRESET mid-frame returns to reset state at once; SPI activity ignored until ss re-falls.
// TESTING
//  Mode0 LSB-first, tx 0x55 loaded, master sends 0xCD -> rx_data_o=0xCD, master gets 0x55.
//  Mode3 MSB-first, tx 0xA3, master sends 0x3C -> rx 0x3C, master sees miso 1,0,1,0,0,0,1,1.
//  No tx byte loaded, frame of 0x81 -> miso all 0, underrun_o=1, rx_data_o=0x81.
//  Two back-to-back frames (ss held low), rx_ready_i low -> overrun_o=1, rx_data_o=2nd byte.
//  ss_i raised after 4 sample edges -> abort_o 1 pulse, rx_valid_o stays 0, next frame correct.
//  PRESET pulsed mid-frame -> all outputs at reset values next cycle; next full frame correct.

Source files
------------

// File: rtl/spi_slave_responder_if.sv
// Host-side byte interface of the SPI responder: TX bytes in, RX bytes out,
// each with its own valid/ready handshake.
interface spi_slave_responder_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI target: oversamples ss/sclk/mosi in the PCLK domain, shifts one frame per
// select, and exchanges bytes with the host through a one-deep TX holding register.
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic cpol_i,
  input  logic cpha_i,
  input  logic lsbfe_i,
  input  logic ss_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic busy_o,
  output logic underrun_o,
  output logic overrun_o,
  output logic abort_o,
  input  logic clr_status_i,
  spi_slave_responder_if.slave host
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic ss_s, sclk_s, mosi_s, ss_prev, sclk_prev;
  logic sclk_rise, sclk_fall, sample_edge, drive_edge;
  logic do_load, do_sample, do_drive, do_done, do_abort;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] tx_hold, tx_shift, rx_shift, load_word;

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Synchroniser chains and edge-history flops; ss history clears low so a
  // select already asserted across reset is not mistaken for a new falling edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;
  assign sample_edge = (cpol_i == cpha_i) ? sclk_rise : sclk_fall;
  assign drive_edge  = (cpol_i == cpha_i) ? sclk_fall : sclk_rise;
  assign load_word   = host.tx_ready_o ? '0 : tx_hold;

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_drive   = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_prev && !ss_s) state_next = LOAD;
        else                  state_next = IDLE;
      end
      LOAD: begin
        do_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (ss_s) begin
          do_abort   = 1'b1;
          state_next = IDLE;
        end else if (sample_edge) begin
          do_sample = 1'b1;
          if (cnt == LAST_BIT) state_next = DONE;
          else                 state_next = SHIFT;
        end else if (drive_edge && cnt != CW'(0) && cnt < CW'(DATA_WIDTH)) begin
          // The CPHA=1 leading edge arrives with cnt==0 and must not advance.
          do_drive = 1'b1;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        do_done = 1'b1;
        if (ss_s) state_next = IDLE;
        else      state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, host handshakes, status flags and registered outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_hold         <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      cnt             <= '0;
      miso_o          <= 1'b0;
      miso_oe_o       <= 1'b0;
      busy_o          <= 1'b0;
      underrun_o      <= 1'b0;
      overrun_o       <= 1'b0;
      abort_o         <= 1'b0;
      host.tx_ready_o <= 1'b1;
      host.rx_data_o  <= '0;
      host.rx_valid_o <= 1'b0;
    end else begin
      // A write landing in the LOAD cycle is kept for the following frame.
      if (host.tx_valid_i && host.tx_ready_o) begin
        tx_hold         <= host.tx_data_i;
        host.tx_ready_o <= 1'b0;
      end else if (do_load) begin
        host.tx_ready_o <= 1'b1;
      end
      if (do_load) begin
        tx_shift <= load_word;
        miso_o   <= lsbfe_i ? load_word[0] : load_word[DATA_WIDTH-1];
        cnt      <= '0;
      end
      if (do_sample) begin
        rx_shift <= lsbfe_i ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                            : {rx_shift[DATA_WIDTH-2:0], mosi_s};
        cnt      <= cnt + CW'(1);
      end
      if (do_drive) begin
        tx_shift <= lsbfe_i ? {1'b0, tx_shift[DATA_WIDTH-1:1]}
                            : {tx_shift[DATA_WIDTH-2:0], 1'b0};
        miso_o   <= lsbfe_i ? tx_shift[1] : tx_shift[DATA_WIDTH-2];
      end
      if (do_done) begin
        host.rx_data_o  <= rx_shift;
        host.rx_valid_o <= 1'b1;
      end else if (host.rx_ready_i) begin
        host.rx_valid_o <= 1'b0;
      end
      if (do_load && host.tx_ready_o)  underrun_o <= 1'b1;
      else if (clr_status_i)           underrun_o <= 1'b0;
      if (do_done && host.rx_valid_o && !host.rx_ready_i) overrun_o <= 1'b1;
      else if (clr_status_i)                              overrun_o <= 1'b0;
      abort_o   <= do_abort;
      busy_o    <= (state_next != IDLE);
      miso_oe_o <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench: a bit-banged SPI master plus a byte-level model of the
// responder (holding register, RX mailbox, sticky flags) predicts every frame.
module tb_spi_slave_responder;
  localparam int H = 8;  // SCLK half-period in PCLK cycles

  logic PCLK = 1'b0;
  logic PRESET, cpol, cpha, lsbfe, ss, sclk, mosi, clr_status;
  logic miso, miso_oe, busy, underrun, overrun, abort;

  spi_slave_responder_if #(.DATA_WIDTH(8)) hif ();

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .cpol_i(cpol), .cpha_i(cpha), .lsbfe_i(lsbfe),
    .ss_i(ss), .sclk_i(sclk), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe),
    .busy_o(busy), .underrun_o(underrun), .overrun_o(overrun), .abort_o(abort),
    .clr_status_i(clr_status), .host(hif)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0, n_bad = 0, abort_cnt = 0;

  always @(negedge PCLK) if (abort === 1'b1) abort_cnt++;

  // Reference model at byte/frame granularity.
  bit m_full, m_rxv, m_und, m_ovr;
  logic [7:0] m_hold, m_rxd;

  function automatic logic [5:0] model_status();
    return {m_rxv, m_und, m_ovr, 1'b0, 1'b0, ~m_full};
  endfunction

  function automatic logic [5:0] dut_status();
    return {hif.rx_valid_o, underrun, overrun, busy, miso_oe, hif.tx_ready_o};
  endfunction

  task automatic model_reset();
    m_full = 0; m_rxv = 0; m_und = 0; m_ovr = 0; m_hold = 8'h00; m_rxd = 8'h00;
  endtask

  task automatic model_start(output logic [7:0] exp_miso);
    exp_miso = m_full ? m_hold : 8'h00;
    if (!m_full) m_und = 1;
    m_full = 0;
  endtask

  task automatic model_done(input logic [7:0] d);
    if (m_rxv) m_ovr = 1;
    m_rxd = d; m_rxv = 1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic host_load(input logic [7:0] d);
    int k;
    k = 0;
    while (hif.tx_ready_o !== 1'b1 && k < 50) begin cyc(1); k++; end
    n_cmp++;
    if (hif.tx_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL tx_ready_timeout: got %b want 1", hif.tx_ready_o);
    end
    hif.tx_data_i = d; hif.tx_valid_i = 1'b1; cyc(1);
    hif.tx_valid_i = 1'b0; cyc(1);
    m_full = 1; m_hold = d;
  endtask

  task automatic host_read();
    hif.rx_ready_i = 1'b1; cyc(1); hif.rx_ready_i = 1'b0; cyc(1);
    m_rxv = 0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1; cyc(1); clr_status = 1'b0; cyc(1);
    m_und = 0; m_ovr = 0;
  endtask

  // Bit-banged master. Select is released one cycle after the final sample edge.
  task automatic spi_frame(input bit c_pol, input bit c_pha, input bit lsb,
                           input logic [7:0] dout, input int n_edges,
                           input bit lower_ss, input bit raise_ss,
                           output logic [7:0] din, output bit oe_ok, output int aborts);
    int a0;
    bit b;
    a0 = abort_cnt; din = 8'h00; oe_ok = 1'b1;
    if (lower_ss) begin
      cpol = c_pol; cpha = c_pha; lsbfe = lsb; sclk = c_pol;
      cyc(2); ss = 1'b0; cyc(4);
    end
    for (int i = 0; i < n_edges; i++) begin
      b = lsb ? dout[i] : dout[7-i];
      if (!c_pha) begin
        mosi = b; cyc(H);
        if (lsb) din[i] = miso; else din[7-i] = miso;
        oe_ok &= (miso_oe === 1'b1);
        sclk = ~c_pol;
        if (i < n_edges - 1) begin cyc(H); sclk = c_pol; end
      end else begin
        cyc(H); sclk = ~c_pol; cyc(1); mosi = b; cyc(H - 1);
        if (lsb) din[i] = miso; else din[7-i] = miso;
        oe_ok &= (miso_oe === 1'b1);
        sclk = c_pol;
      end
    end
    cyc(1);
    if (raise_ss) ss = 1'b1;
    cyc(H); sclk = c_pol; cyc(H);
    aborts = abort_cnt - a0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; cyc(3); PRESET = 1'b0; cyc(1);
    model_reset();
    n_cmp++;
    if (dut_status() !== 6'b000001) begin
      n_bad++; $display("FAIL reset_status: got %b want %b", dut_status(), 6'b000001);
    end
    n_cmp++;
    if ({hif.rx_data_o, miso, abort} !== 10'h000) begin
      n_bad++; $display("FAIL reset_data: got %h want 000", {hif.rx_data_o, miso, abort});
    end
  endtask

  // One full frame in a given mode with the host optionally preloading a byte.
  task automatic run_checked_frame(input string name, input bit c_pol, input bit c_pha,
                                   input bit lsb, input bit do_load, input logic [7:0] tx,
                                   input logic [7:0] rx);
    logic [7:0] got, exp;
    bit oe_ok;
    int ab;
    if (do_load) host_load(tx);
    model_start(exp);
    spi_frame(c_pol, c_pha, lsb, rx, 8, 1'b1, 1'b1, got, oe_ok, ab);
    model_done(rx);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL %s_miso: got %h want %h", name, got, exp); end
    n_cmp++;
    if (hif.rx_data_o !== m_rxd) begin
      n_bad++; $display("FAIL %s_rx_data: got %h want %h", name, hif.rx_data_o, m_rxd);
    end
    n_cmp++;
    if (dut_status() !== model_status()) begin
      n_bad++; $display("FAIL %s_status: got %b want %b", name, dut_status(), model_status());
    end
    n_cmp++;
    if ({oe_ok, ab} !== {1'b1, 32'd0}) begin
      n_bad++; $display("FAIL %s_oe_abort: got oe_ok=%b aborts=%0d want 1/0", name, oe_ok, ab);
    end
  endtask

  task automatic test_mode0_lsb();
    run_checked_frame("mode0_lsb", 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 8'hCD);
    host_read();
  endtask

  task automatic test_mode3_msb();
    run_checked_frame("mode3_msb", 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 8'h3C);
    host_read();
  endtask

  task automatic test_underrun();
    run_checked_frame("underrun", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h81);
    pulse_clr();
    n_cmp++;
    if (underrun !== 1'b0) begin n_bad++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    host_read();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2, e1, e2;
    bit ok1, ok2;
    int ab1, ab2;
    host_load(8'h11);
    model_start(e1);
    spi_frame(1'b1, 1'b0, 1'b0, 8'h5A, 8, 1'b1, 1'b0, got1, ok1, ab1);
    model_done(8'h5A);
    model_start(e2);
    spi_frame(1'b1, 1'b0, 1'b0, 8'hA5, 8, 1'b0, 1'b1, got2, ok2, ab2);
    model_done(8'hA5);
    n_cmp++;
    if ({got1, got2} !== {e1, e2}) begin
      n_bad++; $display("FAIL b2b_miso: got %h want %h", {got1, got2}, {e1, e2});
    end
    n_cmp++;
    if (hif.rx_data_o !== m_rxd) begin
      n_bad++; $display("FAIL b2b_rx_data: got %h want %h", hif.rx_data_o, m_rxd);
    end
    n_cmp++;
    if (dut_status() !== model_status()) begin
      n_bad++; $display("FAIL b2b_status: got %b want %b", dut_status(), model_status());
    end
    pulse_clr();
    host_read();
  endtask

  task automatic test_abort();
    logic [7:0] got, exp;
    bit oe_ok;
    int ab;
    host_load(8'h3E);
    model_start(exp);
    spi_frame(1'b0, 1'b0, 1'b1, 8'hF0, 4, 1'b1, 1'b1, got, oe_ok, ab);
    n_cmp++;
    if (ab !== 1) begin n_bad++; $display("FAIL abort_pulses: got %0d want 1", ab); end
    n_cmp++;
    if (got[3:0] !== exp[3:0]) begin
      n_bad++; $display("FAIL abort_partial_miso: got %h want %h", got[3:0], exp[3:0]);
    end
    n_cmp++;
    if (dut_status() !== model_status()) begin
      n_bad++; $display("FAIL abort_status: got %b want %b", dut_status(), model_status());
    end
    run_checked_frame("after_abort", 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h96);
  endtask

  task automatic test_preset_midframe();
    logic [7:0] got;
    bit oe_ok, busy_seen;
    int ab;
    host_load(8'hC3);
    spi_frame(1'b0, 1'b1, 1'b0, 8'h6B, 3, 1'b1, 1'b0, got, oe_ok, ab);
    PRESET = 1'b1; cyc(1);
    n_cmp++;
    if (dut_status() !== 6'b000001) begin
      n_bad++; $display("FAIL preset_status: got %b want %b", dut_status(), 6'b000001);
    end
    n_cmp++;
    if ({hif.rx_data_o, miso, abort} !== 10'h000) begin
      n_bad++; $display("FAIL preset_data: got %h want 000", {hif.rx_data_o, miso, abort});
    end
    PRESET = 1'b0;
    model_reset();
    busy_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk = ~sclk;
      for (int j = 0; j < H; j++) begin cyc(1); busy_seen |= (busy !== 1'b0); end
    end
    n_cmp++;
    if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL preset_ignore: got busy=1 want 0"); end
    ss = 1'b1; cyc(4);
    run_checked_frame("after_preset", 1'b0, 1'b1, 1'b0, 1'b1, 8'h2D, 8'hB4);
  endtask

  task automatic test_random();
    logic [7:0] tx, rx;
    bit p, h, l;
    for (int n = 0; n < 8; n++) begin
      p = 1'($urandom_range(0, 1)); h = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
      tx = 8'($urandom_range(0, 255)); rx = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) host_read();
      if ($urandom_range(0, 3) == 0) pulse_clr();
      run_checked_frame("random", p, h, l, ($urandom_range(0, 3) != 0) && !m_full, tx, rx);
    end
  endtask

  initial begin
    PRESET = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; ss = 1'b1; sclk = 1'b0;
    mosi = 1'b0; clr_status = 1'b0;
    hif.tx_data_i = 8'h00; hif.tx_valid_i = 1'b0; hif.rx_ready_i = 1'b0;
    test_reset();
    test_mode0_lsb();
    test_mode3_msb();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_preset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
